// File: rtl/ntt_stage_scheduler.sv
// NTT control FSM: coefficient load, log2(N) butterfly stages, natural-order readout.
// Optional NTT_STALL_CNT_EN adds a 16-bit fifo_full stall counter output.

module ntt_stage_scheduler #(
  parameter int N_LOG2 = 7,
  parameter int BF_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              fifo_full,
  output logic              busy,
  output logic              ld_we,
  output logic [N_LOG2-1:0] ld_addr,
  output logic              bf_valid,
  output logic [N_LOG2-1:0] bf_addr_a,
  output logic [N_LOG2-1:0] bf_addr_b,
  output logic [N_LOG2-1:0] bf_tw_idx,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr,
  output logic              out_valid,
  output logic              done
`ifdef NTT_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CW = N_LOG2 + 1;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] N_LAST = CW'((1 << N_LOG2) - 1);
  localparam logic [CW-1:0] HALF   = CW'(1 << (N_LOG2 - 1));
  localparam logic [CW-1:0] H_LAST = CW'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [DW-1:0] D_LAST = DW'(BF_LAT - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DRAIN,
    S_OUT,
    S_FIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt;
  logic [CW-1:0] len;
  logic [CW-1:0] k;
  logic [CW-1:0] start;
  logic [CW-1:0] j;
  logic [CW-1:0] bcnt;
  logic [DW-1:0] dcnt;

  logic          grp_end;
  logic [CW-1:0] start_nx;

  assign grp_end  = (j == start + len - ONE);
  assign start_nx = start + (len << 1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Strobes are combinational, so reset must mask them in its own cycle.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    bf_valid  = 1'b0;
    bf_addr_a = '0;
    bf_addr_b = '0;
    bf_tw_idx = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    if (!rst) begin
      busy = (state != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            ld_we    = 1'b1;
            state_nx = S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            ld_we   = 1'b1;
            ld_addr = N_LOG2'(cnt);
            if (cnt == N_LAST) state_nx = S_CALC;
          end
        end
        S_CALC: begin
          bf_valid  = 1'b1;
          bf_addr_a = N_LOG2'(j);
          bf_addr_b = N_LOG2'(j + len);
          bf_tw_idx = N_LOG2'(k);
          if (bcnt == H_LAST) state_nx = S_DRAIN;
        end
        S_DRAIN: begin
          if (dcnt == D_LAST) begin
            state_nx = (len == ONE) ? S_OUT : S_CALC;
          end
        end
        S_OUT: begin
          if (!fifo_full) begin
            rd_en   = 1'b1;
            rd_addr = N_LOG2'(cnt);
            if (cnt == N_LAST) state_nx = S_FIN;
          end
        end
        S_FIN: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      len       <= '0;
      k         <= '0;
      start     <= '0;
      j         <= '0;
      bcnt      <= '0;
      dcnt      <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= rd_en;
      done      <= rd_en && (cnt == N_LAST);
      unique case (state)
        S_IDLE: begin
          if (in_valid) cnt <= ONE;
        end
        S_LOAD: begin
          if (in_valid) begin
            if (cnt == N_LAST) begin
              cnt   <= '0;
              len   <= HALF;
              k     <= ONE;
              start <= '0;
              j     <= '0;
              bcnt  <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_CALC: begin
          if (bcnt == H_LAST) begin
            bcnt <= '0;
            dcnt <= '0;
          end else begin
            bcnt <= bcnt + ONE;
          end
          // Last butterfly of a group: hop to the next group, new twiddle.
          if (grp_end) begin
            start <= start_nx;
            j     <= start_nx;
            k     <= k + ONE;
          end else begin
            j <= j + ONE;
          end
        end
        S_DRAIN: begin
          if (dcnt == D_LAST) begin
            dcnt  <= '0;
            len   <= len >> 1;
            start <= '0;
            j     <= '0;
            if (len == ONE) cnt <= '0;
          end else begin
            dcnt <= dcnt + D_ONE;
          end
        end
        S_OUT: begin
          if (rd_en) cnt <= (cnt == N_LAST) ? '0 : cnt + ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef NTT_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && in_valid) begin
      stall_cnt <= '0;
    end else if (state == S_OUT && fifo_full &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Bench for ntt_stage_scheduler: logs every strobe and compares the
// trace with a Cooley-Tukey schedule model built from plain loops.

module tb_ntt_stage_scheduler;

  localparam int NL = 7;
  localparam int N  = 1 << NL;
  localparam int H  = N / 2;
  localparam int B  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          fifo_full = 1'b0;
  logic          busy, ld_we, bf_valid, rd_en, out_valid, done;
  logic [NL-1:0] ld_addr, bf_addr_a, bf_addr_b, bf_tw_idx, rd_addr;
`ifdef NTT_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  ntt_stage_scheduler #(.N_LOG2(NL), .BF_LAT(B)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .fifo_full(fifo_full), .busy(busy),
    .ld_we(ld_we), .ld_addr(ld_addr),
    .bf_valid(bf_valid), .bf_addr_a(bf_addr_a),
    .bf_addr_b(bf_addr_b), .bf_tw_idx(bf_tw_idx),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .out_valid(out_valid), .done(done)
`ifdef NTT_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
  } ev_t;

  ev_t ld_q[$];
  ev_t bf_q[$];
  ev_t rd_q[$];
  ev_t exp_q[$];
  int  ov_q[$];
  int  done_q[$];
  bit  ff_hist[int];
  bit  busy_hist[int];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ff_hist[cyc]   = fifo_full;
    busy_hist[cyc] = busy;
    if (ld_we)
      ld_q.push_back('{cyc, int'(ld_addr), 0, 0});
    if (bf_valid)
      bf_q.push_back('{cyc, int'(bf_addr_a),
                      int'(bf_addr_b), int'(bf_tw_idx)});
    if (rd_en)
      rd_q.push_back('{cyc, int'(rd_addr), int'(fifo_full), 0});
    if (out_valid) ov_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
  end

  // Stage s uses half-size len=N>>(s+1); group g uses twiddle 2^s+g.
  // cyc holds the issue slot relative to the first butterfly.
  function automatic void build_model();
    exp_q.delete();
    for (int s = 0; s < NL; s++) begin
      int len = N >> (s + 1);
      for (int g = 0; g < N / (2 * len); g++)
        for (int i = 0; i < len; i++)
          exp_q.push_back('{s * (H + B) + g * len + i,
                            g * 2 * len + i,
                            g * 2 * len + i + len,
                            (1 << s) + g});
    end
  endfunction

  task automatic clear_logs();
    ld_q.delete();
    bf_q.delete();
    rd_q.delete();
    ov_q.delete();
    done_q.delete();
    ff_hist.delete();
    busy_hist.delete();
  endtask

  task automatic drive_load(input int gap);
    for (int i = 0; i < N; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (i < N - 1)
        repeat (g) begin
          @(posedge clk);
          #1;
        end
    end
  endtask

  // mode 0: fifo free; 1: 20-cycle stall once 50 reads issued;
  // 2: keep fifo_full until 4 cycles into OUT, then toggle.
  task automatic run_out(input int mode, input bit noise,
                         output bit ok);
    bit stalled;
    int since;
    stalled = 0;
    since = -1;
    ok = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (noise) in_valid = 1'($urandom_range(0, 1));
      if (mode == 1 && !stalled && rd_q.size() == 50) begin
        fifo_full = 1'b1;
        repeat (20) begin
          @(posedge clk);
          #1;
        end
        fifo_full = 1'b0;
        stalled = 1;
      end
      if (mode == 2) begin
        if (bf_q.size() == H * NL && since < 0) since = 0;
        if (since >= 0) since++;
        if (since >= 8) fifo_full = ~fifo_full;
      end
      @(negedge clk);
      if (done) begin
        ok = 1;
        in_valid = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
    fifo_full = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, ld_we, ld_addr, bf_valid, bf_addr_a, bf_addr_b,
         bf_tw_idx, rd_en, rd_addr, out_valid, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, ld_we, ld_addr, bf_valid, bf_addr_a,
                bf_addr_b, bf_tw_idx, rd_en, rd_addr,
                out_valid, done});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ld_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b ld_we=%b want 0 0",
               busy, ld_we);
    end
`ifdef NTT_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    int rbase;
    clear_logs();
    drive_load(0);
    run_out(0, 0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_done got=timeout want=done");
    end
    checks++;
    if (ld_q.size() != N) begin
      errors++;
      $display("FAIL b2b_ld_count got=%0d want=%0d", ld_q.size(), N);
    end
    for (int i = 0; i < ld_q.size() && i < N; i++) begin
      checks++;
      if (ld_q[i].a != i || ld_q[i].cyc != ld_q[0].cyc + i) begin
        errors++;
        $display("FAIL b2b_ld[%0d] got addr=%0d cyc=%0d want %0d %0d",
                 i, ld_q[i].a, ld_q[i].cyc, i, ld_q[0].cyc + i);
      end
    end
    checks++;
    if (bf_q.size() != H * NL) begin
      errors++;
      $display("FAIL b2b_bf_count got=%0d want=%0d",
               bf_q.size(), H * NL);
    end
    base = (ld_q.size() > 0) ? ld_q[ld_q.size() - 1].cyc + 1 : 0;
    for (int i = 0; i < bf_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (bf_q[i].a != exp_q[i].a || bf_q[i].b != exp_q[i].b ||
          bf_q[i].tw != exp_q[i].tw ||
          bf_q[i].cyc != base + exp_q[i].cyc) begin
        errors++;
        $display("FAIL b2b_bf[%0d] got (%0d,%0d) tw=%0d cyc=%0d want (%0d,%0d) tw=%0d cyc=%0d",
                 i, bf_q[i].a, bf_q[i].b, bf_q[i].tw, bf_q[i].cyc,
                 exp_q[i].a, exp_q[i].b, exp_q[i].tw,
                 base + exp_q[i].cyc);
      end
    end
    checks++;
    if (rd_q.size() != N || ov_q.size() != N) begin
      errors++;
      $display("FAIL b2b_rd_count got rd=%0d ov=%0d want %0d",
               rd_q.size(), ov_q.size(), N);
    end
    rbase = (bf_q.size() > 0) ? bf_q[bf_q.size() - 1].cyc + B + 1 : 0;
    for (int i = 0; i < rd_q.size() && i < ov_q.size(); i++) begin
      checks++;
      if (rd_q[i].a != i || rd_q[i].cyc != rbase + i ||
          ov_q[i] != rd_q[i].cyc + 1) begin
        errors++;
        $display("FAIL b2b_rd[%0d] got addr=%0d cyc=%0d ov=%0d want %0d %0d %0d",
                 i, rd_q[i].a, rd_q[i].cyc, ov_q[i],
                 i, rbase + i, rbase + i + 1);
      end
    end
    checks++;
    if (done_q.size() != 1 || ov_q.size() == 0 ||
        done_q[0] != ov_q[ov_q.size() - 1]) begin
      errors++;
      $display("FAIL b2b_done_pulse got count=%0d want 1 on last out_valid",
               done_q.size());
    end
    if (done_q.size() > 0) begin
      checks++;
      if (busy_hist[done_q[0]] !== 1'b1 ||
          busy_hist[done_q[0] + 1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy_fall got %b%b want 10",
                 busy_hist[done_q[0]], busy_hist[done_q[0] + 1]);
      end
    end
  endtask

  task automatic test_gapped_stall();
    bit ok;
    clear_logs();
    drive_load(5);
    run_out(1, 0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_done got=timeout want=done");
    end
    for (int i = 0; i < ld_q.size(); i++) begin
      checks++;
      if (ld_q[i].a != i || ld_q[i].cyc != ld_q[0].cyc + 6 * i) begin
        errors++;
        $display("FAIL gap_ld[%0d] got addr=%0d cyc=%0d want %0d %0d",
                 i, ld_q[i].a, ld_q[i].cyc, i, ld_q[0].cyc + 6 * i);
      end
    end
    checks++;
    if (ld_q.size() != N || bf_q.size() == 0 ||
        bf_q[0].cyc != ld_q[ld_q.size() - 1].cyc + 1) begin
      errors++;
      $display("FAIL gap_calc_start got ld=%0d bf=%0d want ld=%0d, bf 1 cycle after",
               ld_q.size(), bf_q.size(), N);
    end
    checks++;
    if (rd_q.size() != N || ov_q.size() != N || done_q.size() != 1) begin
      errors++;
      $display("FAIL stall_counts got rd=%0d ov=%0d done=%0d want %0d %0d 1",
               rd_q.size(), ov_q.size(), done_q.size(), N, N);
    end
    for (int i = 0; i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i].a != i) begin
        errors++;
        $display("FAIL stall_rd[%0d] got=%0d want=%0d",
                 i, rd_q[i].a, i);
      end
    end
    if (rd_q.size() > 50) begin
      checks++;
      if (rd_q[50].cyc - rd_q[49].cyc != 21) begin
        errors++;
        $display("FAIL stall_gap got=%0d want=21",
                 rd_q[50].cyc - rd_q[49].cyc);
      end
    end
`ifdef NTT_STALL_CNT_EN
    repeat (4) @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL stall_cnt got=%0d want=20", stall_cnt);
    end
`endif
  endtask

  task automatic test_fifo_toggle();
    bit ok;
    int entry;
    int first_free;
    int want_stall;
    clear_logs();
    fifo_full = 1'b1;
    drive_load(0);
    run_out(2, 0, ok);
    checks++;
    if (!ok || rd_q.size() != N || bf_q.size() == 0) begin
      errors++;
      $display("FAIL tog_run got ok=%0d rd=%0d want 1 %0d",
               ok, rd_q.size(), N);
    end else begin
      entry = bf_q[bf_q.size() - 1].cyc + B + 1;
      first_free = entry;
      while (ff_hist[first_free] && first_free < entry + 100)
        first_free++;
      checks++;
      if (rd_q[0].cyc != first_free || rd_q[0].a != 0) begin
        errors++;
        $display("FAIL tog_first_rd got cyc=%0d addr=%0d want %0d 0",
                 rd_q[0].cyc, rd_q[0].a, first_free);
      end
      for (int i = 1; i < N; i++) begin
        bit missed;
        missed = 0;
        for (int c = rd_q[i - 1].cyc + 1; c < rd_q[i].cyc; c++)
          if (!ff_hist[c]) missed = 1;
        checks++;
        if (rd_q[i].a != i || rd_q[i].b != 0 || missed) begin
          errors++;
          $display("FAIL tog_rd[%0d] got addr=%0d ff=%0d missed=%0d want %0d 0 0",
                   i, rd_q[i].a, rd_q[i].b, missed, i);
        end
      end
      want_stall = 0;
      for (int c = entry; c <= rd_q[N - 1].cyc; c++)
        if (ff_hist[c]) want_stall++;
`ifdef NTT_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 16'(want_stall)) begin
        errors++;
        $display("FAIL tog_stall_cnt got=%0d want=%0d",
                 stall_cnt, want_stall);
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit hit;
    hit = 0;
    clear_logs();
    drive_load(0);
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(posedge clk);
      #1;
      if (bf_q.size() >= 3 * H + 10) hit = 1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!hit || {busy, ld_we, bf_valid, rd_en,
                 out_valid, done} !== 6'b0) begin
      errors++;
      $display("FAIL mrst_during got hit=%0d strobes=%b want 1 000000",
               hit, {busy, ld_we, bf_valid, rd_en, out_valid, done});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    checks++;
    if ({busy, ld_we, ld_addr, bf_valid, bf_addr_a, bf_addr_b,
         bf_tw_idx, rd_en, rd_addr, out_valid, done} !== '0) begin
      errors++;
      $display("FAIL mrst_after got=%h want=0",
               {busy, ld_we, ld_addr, bf_valid, bf_addr_a,
                bf_addr_b, bf_tw_idx, rd_en, rd_addr,
                out_valid, done});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bf_q.size() + rd_q.size() + ov_q.size() + done_q.size() != 0) begin
      errors++;
      $display("FAIL mrst_quiet got bf=%0d rd=%0d ov=%0d want 0",
               bf_q.size(), rd_q.size(), ov_q.size());
    end
    @(posedge clk);
    #1;
    drive_load(-1);
    run_out(0, 0, ok);
    checks++;
    if (!ok || bf_q.size() != H * NL || rd_q.size() != N ||
        ov_q.size() != N || done_q.size() != 1) begin
      errors++;
      $display("FAIL mrst_rerun got ok=%0d bf=%0d rd=%0d ov=%0d done=%0d",
               ok, bf_q.size(), rd_q.size(), ov_q.size(), done_q.size());
    end
    for (int i = 0; i < bf_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (bf_q[i].a != exp_q[i].a || bf_q[i].b != exp_q[i].b ||
          bf_q[i].tw != exp_q[i].tw ||
          bf_q[i].cyc - bf_q[0].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL mrst_bf[%0d] got (%0d,%0d) tw=%0d want (%0d,%0d) tw=%0d",
                 i, bf_q[i].a, bf_q[i].b, bf_q[i].tw,
                 exp_q[i].a, exp_q[i].b, exp_q[i].tw);
      end
    end
  endtask

  task automatic test_ignore_in_valid();
    bit ok;
    int span;
    clear_logs();
    drive_load(-1);
    run_out(0, 1, ok);
    span = H * NL - 1 + (NL - 1) * B;
    checks++;
    if (!ok || ld_q.size() != N) begin
      errors++;
      $display("FAIL ign_ld_count got ok=%0d ld=%0d want 1 %0d",
               ok, ld_q.size(), N);
    end
    for (int i = 0; i < ld_q.size(); i++) begin
      checks++;
      if (ld_q[i].a != i) begin
        errors++;
        $display("FAIL ign_ld[%0d] got=%0d want=%0d",
                 i, ld_q[i].a, i);
      end
    end
    checks++;
    if (bf_q.size() != H * NL || ld_q.size() == 0 ||
        bf_q[0].cyc != ld_q[ld_q.size() - 1].cyc + 1 ||
        bf_q[bf_q.size() - 1].cyc - bf_q[0].cyc != span) begin
      errors++;
      $display("FAIL ign_schedule got bf=%0d want bf=%0d span=%0d",
               bf_q.size(), H * NL, span);
    end
    checks++;
    if (rd_q.size() != N || done_q.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_out got rd=%0d done=%0d busy=%b want %0d 1 0",
               rd_q.size(), done_q.size(), busy, N);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_back_to_back();
    test_gapped_stall();
    test_fifo_toggle();
    test_mid_reset();
    test_ignore_in_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
